// File: rtl/rev_cla_seq.sv
// Multi-cycle reversible CLA adder/subtractor: one 4-bit slice per cycle forward,
// then optional inverse slices (MSB slice first) rebuild the operands from sum and garbage.
module rev_cla_seq #(
  parameter int WIDTH     = 16,
  parameter bit UNCOMPUTE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic [WIDTH-1:0] a_rec,
  output logic [WIDTH-1:0] b_rec,
  output logic             cin_rec,
  output logic             rec_err,
  output logic             busy
);
  localparam int NS = WIDTH / 4;
  localparam int KW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FWD, S_REV, S_DONE} state_t;
  state_t r_state, w_state_nxt;

  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_a, r_b, r_beff;
  logic             r_cin, r_sub, r_carry;
  logic [WIDTH-1:0] r_sum, r_pg, r_prq, r_prr, r_pcq, r_pcr, r_pout, r_sumr;
  logic             r_cout, r_cmsb;
  logic [WIDTH-1:0] r_arec, r_brec;
  logic             r_cin_rec, r_rec_err, r_anc_bad;

  int               w_base;
  logic [3:0]       w_fa, w_fb, w_p, w_g, w_pc, w_prr, w_pcr, w_fs;
  logic [4:0]       w_fc;
  logic [3:0]       w_ia, w_ib;
  logic             w_ianc_bad, w_c0_rec, w_cin_rec_nxt, w_rec_err_nxt;
  logic [WIDTH-1:0] w_arec_nxt, w_brec_nxt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_state_nxt = S_FWD;
      S_FWD:  if (r_k == K_LAST) w_state_nxt = UNCOMPUTE ? S_REV : S_DONE;
      S_REV:  if (r_k == '0) w_state_nxt = S_DONE;
      S_DONE: if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Forward slice: Peres p/g, Fredkin AND (p&c) then Fredkin OR (g|pc), Peres sum.
  always_comb begin
    logic [4:0] c;
    w_base = 4 * int'(r_k);
    w_fa   = r_a[w_base +: 4];
    w_fb   = r_beff[w_base +: 4];
    c      = {4'b0000, r_carry};
    w_p    = w_fa ^ w_fb;
    w_g    = w_fa & w_fb;
    w_pc   = '0;
    w_prr  = '0;
    w_pcr  = '0;
    for (int i = 0; i < 4; i++) begin
      w_pc[i]  = w_p[i] & c[i];
      w_prr[i] = ~w_p[i] & c[i];
      w_pcr[i] = w_g[i] ? w_pc[i] : 1'b1;
      c[i+1]   = w_g[i] | w_pc[i];
    end
    w_fs = w_p ^ c[3:0];
    w_fc = c;
  end

  // Inverse slice works only from stored sum, carry and garbage; every ancilla
  // that should return to its constant is checked so corrupted garbage is caught.
  always_comb begin
    logic [3:0] s_sum, s_pg, s_prq, s_prr, s_pcq, s_pcr, s_pout, s_sumr;
    logic       cn, p, g, pc_r, one_r, zero_r, c_s, c_a, be;
    s_sum  = r_sum[w_base +: 4];
    s_pg   = r_pg[w_base +: 4];
    s_prq  = r_prq[w_base +: 4];
    s_prr  = r_prr[w_base +: 4];
    s_pcq  = r_pcq[w_base +: 4];
    s_pcr  = r_pcr[w_base +: 4];
    s_pout = r_pout[w_base +: 4];
    s_sumr = r_sumr[w_base +: 4];
    cn         = r_carry;
    w_ia       = '0;
    w_ib       = '0;
    w_ianc_bad = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      p      = s_pout[i];
      c_s    = s_sum[i] ^ p;
      g      = s_pcq[i];
      pc_r   = g ? s_pcr[i] : cn;
      one_r  = g ? cn : s_pcr[i];
      zero_r = p ? s_prr[i] : pc_r;
      c_a    = p ? pc_r : s_prr[i];
      be     = p ^ s_pg[i];
      w_ia[i] = s_pg[i];
      w_ib[i] = be ^ r_sub;
      w_ianc_bad = w_ianc_bad | (s_sumr[i] ^ (p & c_s)) | (pc_r ^ s_prq[i]) | ~one_r
                   | zero_r | (c_s ^ c_a) | (g ^ (s_pg[i] & be));
      cn = c_a;
    end
    w_c0_rec   = cn;
    w_arec_nxt = r_arec;
    w_arec_nxt[w_base +: 4] = w_ia;
    w_brec_nxt = r_brec;
    w_brec_nxt[w_base +: 4] = w_ib;
    w_cin_rec_nxt = w_c0_rec ^ r_sub;
    w_rec_err_nxt = (w_arec_nxt != r_a) | (w_brec_nxt != r_b) | (w_cin_rec_nxt != r_cin)
                    | r_anc_bad | w_ianc_bad;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_k       <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_beff    <= '0;
      r_cin     <= 1'b0;
      r_sub     <= 1'b0;
      r_carry   <= 1'b0;
      r_sum     <= '0;
      r_pg      <= '0;
      r_prq     <= '0;
      r_prr     <= '0;
      r_pcq     <= '0;
      r_pcr     <= '0;
      r_pout    <= '0;
      r_sumr    <= '0;
      r_cout    <= 1'b0;
      r_cmsb    <= 1'b0;
      r_arec    <= '0;
      r_brec    <= '0;
      r_cin_rec <= 1'b0;
      r_rec_err <= 1'b0;
      r_anc_bad <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_a       <= a;
          r_b       <= b;
          r_cin     <= cin;
          r_sub     <= sub;
          r_beff    <= sub ? ~b : b;
          r_carry   <= cin ^ sub;
          r_k       <= '0;
          r_anc_bad <= 1'b0;
        end
        S_FWD: begin
          r_sum[w_base +: 4]  <= w_fs;
          r_pg[w_base +: 4]   <= w_fa;
          r_prq[w_base +: 4]  <= w_pc;
          r_prr[w_base +: 4]  <= w_prr;
          r_pcq[w_base +: 4]  <= w_g;
          r_pcr[w_base +: 4]  <= w_pcr;
          r_pout[w_base +: 4] <= w_p;
          r_sumr[w_base +: 4] <= w_pc;
          r_carry <= w_fc[4];
          if (r_k == K_LAST) begin
            r_cout <= w_fc[4];
            r_cmsb <= w_fc[3];
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        S_REV: begin
          r_arec    <= w_arec_nxt;
          r_brec    <= w_brec_nxt;
          r_carry   <= w_c0_rec;
          r_anc_bad <= r_anc_bad | w_ianc_bad;
          if (r_k == '0) begin
            r_cin_rec <= w_cin_rec_nxt;
            r_rec_err <= w_rec_err_nxt;
          end else begin
            r_k <= r_k - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state == S_FWD) || (r_state == S_REV);
  assign out_valid = (r_state == S_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign overflow  = r_cmsb ^ r_cout;
  assign a_rec     = r_arec;
  assign b_rec     = r_brec;
  assign cin_rec   = r_cin_rec;
  assign rec_err   = r_rec_err;
endmodule
